// File: rtl/dec_digits_to_binary_pkg.sv
// rtl/dec_digits_to_binary_pkg.sv - shared states and constants for the decimal-to-binary converter
package dec_digits_to_binary_pkg;

    localparam int WIDTH   = 13;
    localparam int DIGITS  = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dec_digits_to_binary_times_ten_add.sv
// rtl/dec_digits_to_binary_times_ten_add.sv - combinational acc*10 + digit
// Ports:
//   value  WIDTH-bit running accumulator
//   digit  4-bit digit to append (already sanitised by the caller)
//   sum    (WIDTH+4)-bit value*10 + digit, wide enough that it never wraps
module times_ten_add #(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       digit,
    output logic [WIDTH+3:0] sum
);

    logic [WIDTH+3:0] x8;
    logic [WIDTH+3:0] x2;
    logic [WIDTH+3:0] dz;

    // value*10 = (value<<3) + (value<<1); extend before shifting so no bits drop.
    assign x8  = {1'b0, value, 3'b000};
    assign x2  = {3'b000, value, 1'b0};
    assign dz  = {{WIDTH{1'b0}}, digit};
    assign sum = x8 + x2 + dz;

endmodule

// File: rtl/dec_digits_to_binary.sv
// rtl/dec_digits_to_binary.sv - serial BCD (MSD first) to binary converter with saturation
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 begins a conversion, only looked at in IDLE
//   digit, digit_valid    BCD digit stream; transfer when digit_valid & digit_ready
//   digit_ready, busy     decoded from state (ACCUM / ACCUM or DONE)
//   done                  one-cycle pulse once the last digit is folded in
//   result                converted value, held until a later conversion completes
//   overflow, digit_err   sticky flags, cleared by start
module dec_digits_to_binary #(
    parameter int WIDTH  = dec_digits_to_binary_pkg::WIDTH,
    parameter int DIGITS = dec_digits_to_binary_pkg::DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       digit,
    input  logic             digit_valid,
    output logic             digit_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             digit_err
);

    import dec_digits_to_binary_pkg::*;

    localparam int               CW        = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]    LAST_IDX  = CW'(DIGITS - 1);
    localparam logic [3:0]       DIGIT_MAX = 4'(BCD_MAX);
    localparam logic [WIDTH-1:0] SAT_VAL   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH+3:0] sum;
    logic [3:0]       d_eff;
    logic             bad_digit;
    logic             xfer;
    logic             last;
    logic             sat;

    assign bad_digit = (digit > DIGIT_MAX);
    assign d_eff     = bad_digit ? 4'd0 : digit;
    assign xfer      = digit_valid && (state == ACCUM);
    assign last      = (count == LAST_IDX);
    // Once saturated the flag alone keeps acc pinned, so later digits cannot
    // bring a wrapped value back into range.
    assign sat       = overflow || (|sum[WIDTH+3:WIDTH]);

    times_ten_add #(.WIDTH(WIDTH)) u_times_ten_add (
        .value (acc),
        .digit (d_eff),
        .sum   (sum)
    );

    always_comb begin
        state_nxt   = state;
        digit_ready = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCUM;
            end
            ACCUM: begin
                digit_ready = 1'b1;
                busy        = 1'b1;
                if (xfer && last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            result    <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        digit_err <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        count <= count + 1'b1;
                        if (bad_digit) digit_err <= 1'b1;
                        if (sat) begin
                            acc      <= SAT_VAL;
                            overflow <= 1'b1;
                        end else begin
                            acc <= sum[WIDTH-1:0];
                        end
                        if (last) begin
                            done   <= 1'b1;
                            result <= sat ? SAT_VAL : sum[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dec_digits_to_binary.md
Name: dec_digits_to_binary

Overview:
- Serial decimal-to-binary converter for the reaction-time datapath. It is the inverse of the divide-by-ten digit path.
- Accepts BCD digits most-significant first and accumulates `acc = acc*10 + digit`.
- Produces a 13-bit binary millisecond value, used for threshold/high-score entry.
- Handshaked digit input, one-cycle done pulse, held result.

Parameters:
- WIDTH, 13, result width in bits (max 8191).
- DIGITS, 4, number of BCD digits per conversion.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a conversion; sampled only in IDLE.
- digit  input  4  BCD digit, MSD first.
- digit_valid  input  1  digit present this cycle.
- digit_ready  output  1  block accepts a digit this cycle.
- busy  output  1  conversion in progress (ACCUM or DONE).
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  converted value; held until next start.
- overflow  output  1  sticky per conversion: value exceeded 2^WIDTH-1.
- digit_err  output  1  sticky per conversion: a digit > 9 was received.

Behaviour:
- Reset, asynchronous: state=IDLE; acc, count, result = 0; done, busy, digit_ready, overflow, digit_err = 0. Reset mid-conversion abandons it with no done pulse.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - digit_ready=0, busy=0.
  - start=1 → acc=0, count=0, overflow=0, digit_err=0, go to ACCUM.
  - result keeps its previous value.
- ACCUM:
  - digit_ready=1, busy=1.
  - A transfer occurs when digit_valid & digit_ready; no transfer leaves everything unchanged. Gaps are allowed.
  - Per accepted digit d:
    - d_eff = (d>9) ? 0 : d. If d>9, set digit_err.
    - Compute sum = (acc<<3) + (acc<<1) + d_eff at WIDTH+4 bits.
    - If sum > 2^WIDTH-1 or overflow is already set: acc = 2^WIDTH-1 and overflow=1. Otherwise acc = sum[WIDTH-1:0].
    - count++.
  - When the DIGITS-th digit is accepted: next state DONE and result is loaded with the updated acc on that same edge.
  - start is ignored in ACCUM.
- DONE:
  - Lasts one cycle: done=1, busy=1, digit_ready=0.
  - Then go to IDLE. start in DONE is ignored.
- Latency: done is high in the cycle immediately after the clock edge that accepted the last digit. Minimum conversion time is DIGITS+1 cycles after start is sampled.
- Saturation: once overflow is set, acc stays at 2^WIDTH-1 for the rest of the conversion.
- Widths: digit zero-extended; the internal sum is WIDTH+4 bits to hold acc*10+9 without wrap.
- Registered outputs: done, result, overflow, digit_err. digit_ready and busy decode directly from state.

Decomposition:
- Shared package/include:
  - State encodings: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Constants: WIDTH=13, DIGITS=4, BCD_MAX=9.
- Sub-module times_ten_add:
  - Purely combinational; output (WIDTH+4)-bit = in*10 + d.
  - Built as shift-3 plus shift-1 plus digit, using the existing 13-bit add/subtract adder style.
  - Instantiated once by the FSM.

Test Plan:
- start, digits 1,2,3,4 back-to-back → result=1234, done pulses exactly 1 cycle after the 4th accept, overflow=0, digit_err=0.
- digits 8,1,9,1 with 2-cycle valid gaps between each → result=8191, overflow=0; digit_ready stays high across the gaps.
- digits 8,1,9,2 → result=8191, overflow=1. Then digits 9,9,9,9 → result=8191, overflow=1. A following start clears overflow.
- digits 0,0xA,0,5 → digit_err=1, result=5 (the invalid digit counts as 0).
- reset asserted after 2 digits accepted → all outputs 0 asynchronously, no done pulse. After deassert, start then 0,0,4,2 → result=42.
- start held high through ACCUM and DONE → only one conversion, a single done pulse. A new conversion starts only when start is sampled in IDLE.
